fir_sym_mac: RTL and testbench

- Parametrised, time-multiplexed symmetric (linear-phase) FIR filter. Successor to the fixed 32-tap parallel low-pass FIR.
- One shared pre-adder/multiplier/accumulator processes NTAP/2 folded tap pairs per sample, with coefficients loaded at run time.
- Sits in the FILTER core between ADC sample capture and downstream DSP blocks. Paced by the same sample-strobe input f_s.

---
 rtl/fir_sym_mac_if.sv | 24 ++
 rtl/fir_sym_mac.sv | 121 ++++++++++++
 tb/tb_fir_sym_mac.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_sym_mac_if.sv
// rtl/fir_sym_mac_if.sv - sample, coefficient and result signals of the symmetric FIR
interface fir_sym_mac_if #(
  parameter int DW   = 12,
  parameter int CW   = 12,
  parameter int NTAP = 32
) ();
  localparam int CAW = $clog2(NTAP / 2);

  logic                 en;
  logic                 f_s;
  logic signed [DW-1:0] din;
  logic                 cf_we;
  logic [CAW-1:0]       cf_addr;
  logic signed [CW-1:0] cf_wdata;
  logic signed [DW-1:0] dout;
  logic                 dout_valid;
  logic                 busy;
  logic                 overrun;

  modport master (output en, f_s, din, cf_we, cf_addr, cf_wdata,
                  input  dout, dout_valid, busy, overrun);
  modport slave  (input  en, f_s, din, cf_we, cf_addr, cf_wdata,
                  output dout, dout_valid, busy, overrun);
endinterface

// File: rtl/fir_sym_mac.sv
// rtl/fir_sym_mac.sv - time-multiplexed symmetric FIR, one folded tap pair per clock
module fir_sym_mac #(
  parameter int DW     = 12,
  parameter int CW     = 12,
  parameter int NTAP   = 32,
  parameter int OSHIFT = 15,
  parameter int ACCW   = DW + CW + 1 + $clog2(NTAP / 2)
) (
  input logic          clk,
  input logic          rst,
  fir_sym_mac_if.slave bus
);
  localparam int HALF = NTAP / 2;
  localparam int AW   = $clog2(NTAP);
  localparam int CAW  = $clog2(HALF);
  localparam int PW   = DW + CW + 1;
  localparam int DW1  = DW + 1;
  localparam int ACW1 = ACCW + 1;
  localparam logic signed [ACCW:0] RBIAS = ACW1'(2 ** (OSHIFT - 1));
  localparam logic signed [ACCW:0] MAXV  = ACW1'(2 ** (DW - 1) - 1);
  localparam logic signed [ACCW:0] MINV  = ACW1'(-(2 ** (DW - 1)));

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;
  state_t state, state_nxt;

  logic                   pl0, pl1, start;
  logic signed [DW-1:0]   xbuf [NTAP];
  logic signed [CW-1:0]   coef [HALF];
  logic [AW-1:0]          wptr, rd_new, rd_old;
  logic [CAW-1:0]         idx;
  logic signed [ACCW-1:0] acc;
  logic signed [DW:0]     pre;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW:0]   rsum, rsh;
  logic signed [DW-1:0]   dout_q, sat;
  logic                   dout_valid_q, overrun_q;

  assign start = pl0 & ~pl1 & bus.en;

  // pair i reads x[n-i] at wptr-1-i and its mirror x[n-(NTAP-1-i)] at wptr+i
  assign rd_new = wptr - AW'(1) - AW'(idx);
  assign rd_old = wptr + AW'(idx);
  assign pre    = DW1'(xbuf[rd_new]) + DW1'(xbuf[rd_old]);
  assign prod   = PW'(pre) * PW'(coef[idx]);
  assign rsum   = ACW1'(acc) + RBIAS;
  assign rsh    = rsum >>> OSHIFT;

  always_comb begin
    sat = rsh[DW-1:0];
    if (rsh > MAXV)
      sat = MAXV[DW-1:0];
    else if (rsh < MINV)
      sat = MINV[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MAC;
      MAC:     if (idx == CAW'(HALF - 1)) state_nxt = ROUND;
      ROUND:   state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pl0          <= 1'b0;
      pl1          <= 1'b0;
      wptr         <= '0;
      idx          <= '0;
      acc          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int k = 0; k < NTAP; k++) xbuf[k] <= '0;
      for (int k = 0; k < HALF; k++) coef[k] <= '0;
    end else begin
      pl0          <= bus.f_s;
      pl1          <= pl0;
      dout_valid_q <= 1'b0;
      if (start && state != IDLE)
        overrun_q <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.cf_we)
            coef[bus.cf_addr] <= bus.cf_wdata;
          if (start) begin
            xbuf[wptr] <= bus.din;
            wptr       <= wptr + AW'(1);
            acc        <= '0;
            idx        <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACCW'(prod);
          idx <= idx + CAW'(1);
        end
        // dout and its strobe land together so both are visible during OUT
        ROUND: begin
          dout_q       <= sat;
          dout_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = (state != IDLE);
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_fir_sym_mac.sv
// tb/tb_fir_sym_mac.sv - randomized and directed checks of fir_sym_mac against a direct-form model
module tb_fir_sym_mac;
  localparam int DW   = 12;
  localparam int CW   = 12;
  localparam int NTAP = 32;
  localparam int HALF = NTAP / 2;
  localparam int LAT  = HALF + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_sym_mac_if #(.DW(DW), .CW(CW), .NTAP(NTAP)) bus ();

  fir_sym_mac #(.DW(DW), .CW(CW), .NTAP(NTAP), .OSHIFT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int hist [NTAP];
  int hm   [HALF];
  bit ovr_m;
  int last_exp;
  int outs [$];
  int dc_h [HALF] = '{35, 58, 103, 164, 245, 345, 463, 596, 741, 891, 1040, 1181, 1304, 1404, 1474, 1511};

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // direct-form sum over all NTAP taps with the mirrored coefficient set
  function automatic int model_out();
    longint y = 0;
    for (int j = 0; j < NTAP; j++)
      y += longint'(hist[j]) * longint'(hm[(j < HALF) ? j : NTAP - 1 - j]);
    y = (y + 64'sd16384) >>> 15;
    if (y > 2047) y = 2047;
    if (y < -2048) y = -2048;
    return int'(y);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NTAP; j++) hist[j] = 0;
    for (int j = 0; j < HALF; j++) hm[j] = 0;
    ovr_m    = 1'b0;
    last_exp = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.en = 1'b1; bus.f_s = 1'b0; bus.din = '0;
    bus.cf_we = 1'b0; bus.cf_addr = '0; bus.cf_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic write_coef(input int k, input int v);
    @(negedge clk);
    bus.cf_we = 1'b1; bus.cf_addr = 4'(k); bus.cf_wdata = 12'(v);
    @(negedge clk);
    bus.cf_we = 1'b0;
    hm[k] = v;
  endtask

  // wr_mode: 0 none, 1 write in the strobe cycle, 2 write during MAC (cycle 5)
  task automatic do_sample(input int d, input bit en_v, input int wr_mode, input int wr_k,
                           input int wr_v, input int ovr_at, input int rst_at);
    int  exp_v;
    int  c;
    bit  seen;
    bit  want;
    exp_v = 0; c = 0; seen = 1'b0;
    want  = en_v && (rst_at < 0);
    @(negedge clk);
    bus.en = en_v; bus.f_s = 1'b1; bus.din = 12'(d);
    @(posedge clk);
    @(negedge clk);
    bus.f_s = 1'b0;
    if (wr_mode != 0) begin
      bus.cf_addr = 4'(wr_k); bus.cf_wdata = 12'(wr_v);
    end
    if (wr_mode == 1) begin
      bus.cf_we = 1'b1;
      hm[wr_k] = wr_v;
    end
    if (en_v) begin
      for (int j = NTAP - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = d;
      exp_v = model_out();
      if (ovr_at >= 0) ovr_m = 1'b1;
    end
    while (c < 25) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      if (bus.dout_valid && !seen) begin
        seen = 1'b1;
        check("latency", c, LAT);
        check("dout", bus.dout, exp_v);
      end
      if (c == 1 && want) check("busy", bus.busy, 1);
      bus.cf_we = (wr_mode == 2 && c == 5);
      if (ovr_at >= 0) bus.f_s = (c == ovr_at);
      if (rst_at >= 0 && c == rst_at) rst = 1'b0;
      if (rst_at >= 0 && c == rst_at + 2) rst = 1'b1;
      if (seen) break;
    end
    check("dv_seen", seen, want);
    if (rst_at >= 0) begin
      model_reset();
      check("rst_dout", bus.dout, 0);
      check("rst_busy", bus.busy, 0);
    end else if (want) begin
      outs.push_back(seen ? int'(bus.dout) : -99999);
      last_exp = exp_v;
    end else begin
      check("hold_dout", bus.dout, last_exp);
    end
    check("overrun", bus.overrun, ovr_m);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.en = 1'b0; bus.f_s = 1'b0; bus.din = '0;
    bus.cf_we = 1'b0; bus.cf_addr = '0; bus.cf_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_dout", bus.dout, 0);
    check("reset_dv", bus.dout_valid, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_ovr", bus.overrun, 0);
    rst = 1'b1;

    // impulse response
    write_coef(0, 1024);
    outs.delete();
    do_sample(1024, 1, 0, 0, 0, -1, -1);
    repeat (40) do_sample(0, 1, 0, 0, 0, -1, -1);
    check("imp_out0", outs[0], 32);
    check("imp_out1", outs[1], 0);
    check("imp_out31", outs[31], 32);
    check("imp_out32", outs[32], 0);

    // DC gain
    do_reset();
    for (int k = 0; k < HALF; k++) write_coef(k, dc_h[k]);
    outs.delete();
    repeat (40) do_sample(1000, 1, 0, 0, 0, -1, -1);
    check("dc_steady", outs[39], 705);

    // saturation both ways
    do_reset();
    for (int k = 0; k < HALF; k++) write_coef(k, 2047);
    outs.delete();
    repeat (40) do_sample(2047, 1, 0, 0, 0, -1, -1);
    check("sat_pos", outs[39], 2047);
    repeat (40) do_sample(-2048, 1, 0, 0, 0, -1, -1);
    check("sat_neg", outs[79], -2048);

    // overrun: second strobe while busy is dropped
    do_reset();
    write_coef(0, 1024);
    outs.delete();
    check("ovr_before", bus.overrun, 0);
    do_sample(1024, 1, 0, 0, 0, 10, -1);
    repeat (35) do_sample(0, 1, 0, 0, 0, -1, -1);
    check("ovr_out0", outs[0], 32);
    check("ovr_out31", outs[31], 32);
    check("ovr_sticky", bus.overrun, 1);
    do_reset();
    check("ovr_cleared", bus.overrun, 0);

    // coefficient write during MAC is ignored, in IDLE it is taken
    write_coef(0, 1024);
    outs.delete();
    do_sample(1024, 1, 2, 3, 500, -1, -1);
    repeat (39) do_sample(0, 1, 0, 0, 0, -1, -1);
    check("cf_busy_out3", outs[3], 0);
    write_coef(3, 500);
    outs.delete();
    do_sample(1024, 1, 0, 0, 0, -1, -1);
    repeat (10) do_sample(0, 1, 0, 0, 0, -1, -1);
    check("cf_idle_out0", outs[0], 32);
    check("cf_idle_out3", outs[3], 16);
    do_sample(700, 1, 1, 1, -300, -1, -1);
    do_sample(-900, 1, 1, 2, 1234, -1, -1);

    // reset mid-MAC, then impulse matches fresh-reset behaviour
    do_sample(500, 1, 0, 0, 0, -1, 8);
    write_coef(0, 1024);
    outs.delete();
    do_sample(1024, 1, 0, 0, 0, -1, -1);
    repeat (31) do_sample(0, 1, 0, 0, 0, -1, -1);
    check("rst_imp_out0", outs[0], 32);
    check("rst_imp_out3", outs[3], 0);
    check("rst_imp_out31", outs[31], 32);

    // randomized stream with disabled strobes and strobe-cycle coefficient writes
    do_reset();
    for (int k = 0; k < HALF; k++) write_coef(k, int'($urandom_range(0, 4095)) - 2048);
    for (int n = 0; n < 60; n++) begin
      int  d;
      bit  e;
      int  wm;
      d  = int'($urandom_range(0, 4095)) - 2048;
      e  = ($urandom_range(0, 7) != 0);
      wm = ($urandom_range(0, 9) == 0) ? 1 : 0;
      do_sample(d, e, wm, int'($urandom_range(0, HALF - 1)), int'($urandom_range(0, 4095)) - 2048, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
